// File: rtl/sm83_timer.sv
// SM83-style DIV/TIMA/TMA/TAC timer block with falling-edge prescaler tap and overflow interrupt.
// Define SM83_TIMER_OVF_DELAY_EN for the 4-clock OVF + 1-clock RELOAD overflow sequence.
module sm83_timer #(
    parameter int                    ADR_WIDTH = 16,
    parameter logic [ADR_WIDTH-1:0]  BASE_ADR  = 16'hff04
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic [7:0]           din,
    input  logic                 wr,
    input  logic                 rd,
    output logic [7:0]           dout,
    output logic                 data_oe,
    output logic                 irq
);
    localparam logic [ADR_WIDTH-1:0] ADR_DIV  = BASE_ADR;
    localparam logic [ADR_WIDTH-1:0] ADR_TIMA = BASE_ADR + ADR_WIDTH'(1);
    localparam logic [ADR_WIDTH-1:0] ADR_TMA  = BASE_ADR + ADR_WIDTH'(2);
    localparam logic [ADR_WIDTH-1:0] ADR_TAC  = BASE_ADR + ADR_WIDTH'(3);

    logic [15:0] r_sys_cnt;
    logic [7:0]  r_tima;
    logic [7:0]  r_tma;
    logic [2:0]  r_tac;
    logic        r_tap_prev;
    logic        r_irq;

    logic       w_sel_div, w_sel_tima, w_sel_tma, w_sel_tac, w_hit;
    logic       w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    logic       w_tap_bit, w_tap, w_fall;
    logic [7:0] w_tma_next;
    logic [7:0] w_tima_next;
    logic       w_irq_next;
    logic [7:0] w_rd_data;

    assign w_sel_div  = (adr == ADR_DIV);
    assign w_sel_tima = (adr == ADR_TIMA);
    assign w_sel_tma  = (adr == ADR_TMA);
    assign w_sel_tac  = (adr == ADR_TAC);
    assign w_hit      = w_sel_div | w_sel_tima | w_sel_tma | w_sel_tac;

    assign w_wr_div  = wr & w_sel_div;
    assign w_wr_tima = wr & w_sel_tima;
    assign w_wr_tma  = wr & w_sel_tma;
    assign w_wr_tac  = wr & w_sel_tac;

    // A TMA write lands in the same clock as any reload that consumes it.
    assign w_tma_next = w_wr_tma ? din : r_tma;

    always_comb begin
        unique case (r_tac[1:0])
            2'b00:   w_tap_bit = r_sys_cnt[9];
            2'b01:   w_tap_bit = r_sys_cnt[3];
            2'b10:   w_tap_bit = r_sys_cnt[5];
            default: w_tap_bit = r_sys_cnt[7];
        endcase
    end

    assign w_tap  = r_tac[2] & w_tap_bit;
    assign w_fall = r_tap_prev & ~w_tap;

`ifdef SM83_TIMER_OVF_DELAY_EN
    typedef enum logic [1:0] {ST_RUN, ST_OVF, ST_RELOAD} state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_ovf_cnt, w_ovf_cnt_next;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        w_state_next   = r_state;
        w_ovf_cnt_next = r_ovf_cnt;
        w_tima_next    = r_tima;
        w_irq_next     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_wr_tima) begin
                    w_tima_next = din;
                end else if (w_fall) begin
                    if (r_tima == 8'hff) begin
                        w_tima_next    = 8'h00;
                        w_state_next   = ST_OVF;
                        w_ovf_cnt_next = 2'd3;
                    end else begin
                        w_tima_next = r_tima + 8'd1;
                    end
                end
            end
            ST_OVF: begin
                if (w_wr_tima) begin
                    w_tima_next  = din;
                    w_state_next = ST_RUN;
                end else if (r_ovf_cnt == 2'd0) begin
                    w_tima_next  = w_tma_next;
                    w_state_next = ST_RELOAD;
                    w_irq_next   = 1'b1;
                end else begin
                    w_ovf_cnt_next = r_ovf_cnt - 2'd1;
                end
            end
            ST_RELOAD: begin
                // TIMA writes are dropped here; TIMA keeps tracking TMA.
                w_tima_next  = w_tma_next;
                w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_ovf_cnt <= 2'd0;
        end else begin
            r_state   <= w_state_next;
            r_ovf_cnt <= w_ovf_cnt_next;
        end
    end
`else
    always_comb begin
        w_tima_next = r_tima;
        w_irq_next  = 1'b0;
        if (w_wr_tima) begin
            w_tima_next = din;
        end else if (w_fall) begin
            if (r_tima == 8'hff) begin
                w_tima_next = w_tma_next;
                w_irq_next  = 1'b1;
            end else begin
                w_tima_next = r_tima + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            r_sys_cnt  <= 16'h0000;
            r_tima     <= 8'h00;
            r_tma      <= 8'h00;
            r_tac      <= 3'b000;
            r_tap_prev <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sys_cnt  <= w_wr_div ? 16'h0000 : r_sys_cnt + 16'd1;
            r_tap_prev <= w_tap;
            r_tima     <= w_tima_next;
            r_tma      <= w_tma_next;
            r_irq      <= w_irq_next;
            if (w_wr_tac) r_tac <= din[2:0];
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (w_sel_div)       w_rd_data = r_sys_cnt[15:8];
        else if (w_sel_tima) w_rd_data = r_tima;
        else if (w_sel_tma)  w_rd_data = r_tma;
        else if (w_sel_tac)  w_rd_data = {5'b11111, r_tac};
    end

    assign data_oe = rd & w_hit;
    assign dout    = data_oe ? w_rd_data : 8'h00;
    assign irq     = r_irq;

endmodule

// File: tb/tb_sm83_timer.sv
// Directed bench for sm83_timer; follows SM83_TIMER_OVF_DELAY_EN when it is defined for the build.
module tb_sm83_timer;
    localparam logic [15:0] A_DIV  = 16'hff04;
    localparam logic [15:0] A_TIMA = 16'hff05;
    localparam logic [15:0] A_TMA  = 16'hff06;
    localparam logic [15:0] A_TAC  = 16'hff07;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  dout;
    logic        data_oe;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int irq_cycles = 0;

    sm83_timer #(.ADR_WIDTH(16), .BASE_ADR(16'hff04)) dut (
        .clk(clk), .reset(reset), .adr(adr), .din(din), .wr(wr), .rd(rd),
        .dout(dout), .data_oe(data_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_cycles++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        adr = a; din = d; wr = 1'b1;
        tick(1);
        wr = 1'b0; adr = 16'h0000; din = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        adr = a; rd = 1'b1;
        #1;
        d = dout; oe = data_oe;
        rd = 1'b0; adr = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr = 1'b0; rd = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        reset = 1'b1; adr = A_TIMA; din = 8'h33; wr = 1'b1;
        tick(2);
        wr = 1'b0; adr = 16'h0000; reset = 1'b0;
        bus_read(A_DIV, d, oe); checks++;
        if (d !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL reset_div: got %h/%b want 00/1", d, oe); end
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_tima_over_wr: got %h want 00", d); end
        bus_read(A_TMA, d, oe); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_tma: got %h want 00", d); end
        bus_read(A_TAC, d, oe); checks++;
        if (d !== 8'hf8) begin errors++; $display("FAIL reset_tac: got %h want f8", d); end
        adr = A_TIMA; #1; checks++;
        if (dout !== 8'h00 || data_oe !== 1'b0) begin errors++; $display("FAIL reset_idle_bus: got %h/%b want 00/0", dout, data_oe); end
        adr = 16'h0000; checks++;
        if (irq !== 1'b0 || irq_cycles != 0) begin errors++; $display("FAIL reset_irq: got %b/%0d want 0/0", irq, irq_cycles); end
    endtask

    task automatic test_prescale();
        logic [7:0] d; logic oe; int ic0;
        do_reset();
        bus_write(A_TMA, 8'h10);
        bus_write(A_TIMA, 8'hfe);
        bus_write(A_DIV, 8'h5a);
        bus_write(A_TAC, 8'h05);
        ic0 = irq_cycles;
        tick(15);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'hfe) begin errors++; $display("FAIL prescale_hold: got %h want fe", d); end
        tick(1);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'hff) begin errors++; $display("FAIL prescale_inc16: got %h want ff", d); end
        tick(16);
`ifdef SM83_TIMER_OVF_DELAY_EN
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL prescale_wrap: got %h/%b want 00/0", d, irq); end
        tick(3);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL prescale_ovf_end: got %h/%b want 00/0", d, irq); end
        tick(1);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h10 || irq !== 1'b1) begin errors++; $display("FAIL prescale_reload: got %h/%b want 10/1", d, irq); end
`else
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h10 || irq !== 1'b1) begin errors++; $display("FAIL prescale_reload: got %h/%b want 10/1", d, irq); end
`endif
        tick(1);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h10 || irq !== 1'b0) begin errors++; $display("FAIL prescale_after: got %h/%b want 10/0", d, irq); end
        checks++;
        if (irq_cycles - ic0 != 1) begin errors++; $display("FAIL prescale_irq_count: got %0d want 1", irq_cycles - ic0); end
    endtask

    task automatic test_div_edge();
        logic [7:0] d; logic oe;
        do_reset();
        bus_write(A_DIV, 8'hff);
        bus_write(A_TAC, 8'h04);
        tick(598);
        bus_read(A_DIV, d, oe); checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL div_count: got %h want 02", d); end
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL div_no_early_inc: got %h want 00", d); end
        bus_write(A_DIV, 8'hff);
        bus_read(A_DIV, d, oe); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL div_clear: got %h want 00", d); end
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL div_edge_wait: got %h want 00", d); end
        tick(1);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL div_edge_inc: got %h want 01", d); end
    endtask

    task automatic test_write_priority();
        logic [7:0] d; logic oe;
        do_reset();
        bus_write(A_DIV, 8'h00);
        bus_write(A_TAC, 8'h05);
        tick(15);
        bus_write(A_TIMA, 8'h55);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL wr_vs_edge: got %h want 55", d); end
        tick(16);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h56) begin errors++; $display("FAIL wr_vs_edge_next: got %h want 56", d); end
    endtask

    task automatic test_bus();
        logic [7:0] d; logic oe;
        do_reset();
        bus_write(A_TAC, 8'h02);
        bus_read(A_TAC, d, oe); checks++;
        if (d !== 8'hfa || oe !== 1'b1) begin errors++; $display("FAIL bus_tac_read: got %h/%b want fa/1", d, oe); end
        bus_read(16'hff08, d, oe); checks++;
        if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL bus_miss_read: got %h/%b want 00/0", d, oe); end
        bus_write(16'hff08, 8'h07);
        bus_write(16'hff03, 8'h07);
        bus_read(A_TAC, d, oe); checks++;
        if (d !== 8'hfa) begin errors++; $display("FAIL bus_miss_write: got %h want fa", d); end
        bus_write(A_TMA, 8'h3c);
        adr = A_TMA; din = 8'haa; wr = 1'b1; rd = 1'b1;
        #1; checks++;
        if (dout !== 8'h3c || data_oe !== 1'b1) begin errors++; $display("FAIL bus_rdwr_old: got %h/%b want 3c/1", dout, data_oe); end
        tick(1);
        wr = 1'b0; checks++;
        if (dout !== 8'haa) begin errors++; $display("FAIL bus_rdwr_new: got %h want aa", dout); end
        rd = 1'b0; adr = 16'h0000;
    endtask

`ifdef SM83_TIMER_OVF_DELAY_EN
    task automatic setup_ovf();
        do_reset();
        bus_write(A_DIV, 8'h00);
        bus_write(A_TAC, 8'h05);
        bus_write(A_TMA, 8'h05);
        bus_write(A_TIMA, 8'hff);
        tick(14);
    endtask

    task automatic test_ovf_cancel();
        logic [7:0] d; logic oe; int ic0;
        setup_ovf();
        ic0 = irq_cycles;
        tick(1);
        bus_write(A_TIMA, 8'h42);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h42) begin errors++; $display("FAIL ovf_cancel_wr: got %h want 42", d); end
        tick(6);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h42 || irq_cycles != ic0) begin errors++; $display("FAIL ovf_cancel_noirq: got %h/%0d want 42/0", d, irq_cycles - ic0); end
    endtask

    task automatic test_reload_writes();
        logic [7:0] d; logic oe; int ic0;
        setup_ovf();
        ic0 = irq_cycles;
        tick(4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reload_irq: got %b want 1", irq); end
        bus_write(A_TMA, 8'h77);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h77 || irq_cycles - ic0 != 1) begin errors++; $display("FAIL reload_tma_wr: got %h/%0d want 77/1", d, irq_cycles - ic0); end
        setup_ovf();
        tick(4);
        bus_write(A_TIMA, 8'h99);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL reload_tima_wr: got %h want 05", d); end
    endtask

    task automatic test_reset_in_ovf();
        logic [7:0] d; logic oe; int ic0;
        setup_ovf();
        ic0 = irq_cycles;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h00 || irq_cycles != ic0) begin errors++; $display("FAIL reset_in_ovf: got %h/%0d want 00/0", d, irq_cycles - ic0); end
    endtask
`else
    task automatic test_overflow_direct();
        logic [7:0] d; logic oe;
        do_reset();
        bus_write(A_DIV, 8'h00);
        bus_write(A_TAC, 8'h05);
        bus_write(A_TMA, 8'h05);
        bus_write(A_TIMA, 8'hff);
        tick(13);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'hff || irq !== 1'b0) begin errors++; $display("FAIL ovf_before: got %h/%b want ff/0", d, irq); end
        tick(1);
        bus_read(A_TIMA, d, oe); checks++;
        if (d !== 8'h05 || irq !== 1'b1) begin errors++; $display("FAIL ovf_reload: got %h/%b want 05/1", d, irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_prescale();
        test_div_edge();
        test_write_priority();
        test_bus();
`ifdef SM83_TIMER_OVF_DELAY_EN
        test_ovf_cancel();
        test_reload_writes();
        test_reset_in_ovf();
`else
        test_overflow_direct();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
